vend_arbiter: RTL and testbench
===============================

VEND_ARBITER -- requirements
Module: vend_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYC, default 8, is the idle cycles allowed in a session with no coin before it is abandoned; legal range 2..255.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 req  input  2  per-port session request; bit0 = port A, bit1 = port B; level-sensitive.
REQ-005 sel  input  2  per-port drink select; 0 = 5-unit drink, 1 = 10-unit drink.
REQ-006 din_a  input  2  port A coin; 0 none, 1 = 5, 2 = 10, 3 illegal.
REQ-007 din_b  input  2  port B coin; same encoding as din_a.
REQ-008 grant  output  2  one-hot owner of the shared dispenser; 0 when idle.
REQ-009 busy  output  1  high whenever grant is nonzero.
REQ-010 drinks_out  output  2  one-cycle pulse; 1 = 5-unit drink, 2 = 10-unit drink, 0 otherwise.
REQ-011 change_out  output  1  one-cycle pulse, coincident with drinks_out, returning 5 units.
REQ-012 refund_out  output  2  one-cycle pulse of refunded credit in 5-unit steps (0 or 1).

Function
REQ-013 FSM states are IDLE, SERVE and DISPENSE; all outputs are registered.
REQ-014 Credit is a 2-bit register in 5-unit steps; price = 1 step if latched sel = 0, 2 steps if latched sel = 1.
REQ-015 Arbitration in IDLE: if req is nonzero, grant the requesting port; if both ports request, grant the port not served last (round-robin).
REQ-016 A grant SHALL load credit to 0, latch sel of the granted port, clear the idle counter and move to SERVE; grant is visible from the next cycle.
REQ-017 In SERVE only the granted port's din is sampled; the other port's din is ignored with no side effect.
REQ-018 din = 3 is treated as no coin; it adds no credit and does not reset the idle counter.
REQ-019 In SERVE, sum = credit + coin; if sum >= price, the FSM enters DISPENSE.
REQ-020 On that transition, drinks_out = latched sel + 1 and change_out = (sum - price == 1) are registered, so both pulse in the first DISPENSE cycle (one cycle after the paying coin).
REQ-021 Sum range is 0..3 with 3-bit intermediate arithmetic; no wrap is permitted.
REQ-022 If sum < price, credit <= sum.
REQ-023 A valid coin clears the idle counter; otherwise the counter increments.
REQ-024 When the counter reaches TIMEOUT_CYC - 1 with no coin, refund_out <= credit is registered, the FSM enters IDLE and grant clears.
REQ-025 If the granted port drops req while credit = 0, the FSM returns to IDLE next cycle with no pulse.
REQ-026 If the granted port drops req while credit > 0, it is ignored and the session continues until payment or timeout.
REQ-027 Changes on sel after the grant are ignored.
REQ-028 DISPENSE lasts exactly one cycle, then goes to IDLE; the last-served pointer updates to the granted port and grant clears.
REQ-029 A new grant can issue on the cycle after DISPENSE, giving a minimum of 3 cycles per session.
REQ-030 drinks_out, change_out and refund_out are never nonzero in the same cycle as a refund/dispense of another session.
REQ-031 refund_out and drinks_out are mutually exclusive.

Reset
REQ-032 rst high at a clock edge forces IDLE, credit = 0, idle counter = 0 and last-served = port B, so port A wins the first tie.
REQ-033 Reset clears grant, busy, drinks_out, change_out and refund_out to 0.
REQ-034 Reset mid-session discards credit with no refund pulse.
REQ-035 rst has priority over all other inputs.

Verification
REQ-036 req=01, sel[0]=0, din_a=1 in the first SERVE cycle -> drinks_out=1 and change_out=0 on the next cycle; grant=00 one cycle later.
REQ-037 Port A, sel=1, din_a=1 then din_a=2 -> drinks_out=2 and change_out=1 one cycle after the second coin.
REQ-038 req=11 from reset -> grant=01 for the first session; after A completes with req still 11, grant=10 next.
REQ-039 Port B granted, sel=1, din_b=1, then no coin for TIMEOUT_CYC cycles -> refund_out=1, drinks_out=0, grant=00.
REQ-040 During a port A session, din_b=2 and din_a=3 -> credit unchanged and no output pulses.
REQ-041 rst asserted in SERVE with credit=1 -> the next cycle shows all outputs 0 and no refund pulse.

Source files
------------

// File: rtl/vend_arbiter.sv
// Two-port vending arbiter: round-robin grant of a shared dispenser, coin
// accumulation in 5-unit steps, dispense with change, and idle-timeout refund.
module vend_arbiter #(
    parameter int unsigned TIMEOUT_CYC = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic [1:0] sel,
    input  logic [1:0] din_a,
    input  logic [1:0] din_b,
    output logic [1:0] grant,
    output logic       busy,
    output logic [1:0] drinks_out,
    output logic       change_out,
    output logic [1:0] refund_out
);

    typedef enum logic [1:0] {IDLE, SERVE, DISPENSE} state_t;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);

    state_t     state;
    logic [1:0] credit;
    logic [7:0] idle_cnt;
    logic       last_b;
    logic       port_b;
    logic       sel_hi;

    logic [1:0] coin;
    logic       coin_ok;
    logic [2:0] coin_val;
    logic [2:0] sum;
    logic [2:0] price;
    logic       owner_req;
    logic       pick_b;

    always_comb begin
        coin      = port_b ? din_b : din_a;
        coin_ok   = (coin == 2'd1) || (coin == 2'd2);
        coin_val  = coin_ok ? {1'b0, coin} : 3'd0;
        sum       = {1'b0, credit} + coin_val;
        price     = sel_hi ? 3'd2 : 3'd1;
        owner_req = port_b ? req[1] : req[0];
        // On a tie, the port that was not served last wins.
        pick_b    = (req == 2'b11) ? ~last_b : req[1];
    end

    always_ff @(posedge clk) begin
        drinks_out <= '0;
        change_out <= 1'b0;
        refund_out <= '0;
        if (rst) begin
            state    <= IDLE;
            credit   <= '0;
            idle_cnt <= '0;
            last_b   <= 1'b1;
            port_b   <= 1'b0;
            sel_hi   <= 1'b0;
            grant    <= '0;
            busy     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req != '0) begin
                        port_b   <= pick_b;
                        sel_hi   <= pick_b ? sel[1] : sel[0];
                        credit   <= '0;
                        idle_cnt <= '0;
                        grant    <= pick_b ? 2'b10 : 2'b01;
                        busy     <= 1'b1;
                        state    <= SERVE;
                    end
                end
                SERVE: begin
                    if (sum >= price) begin
                        drinks_out <= sel_hi ? 2'd2 : 2'd1;
                        change_out <= ((sum - price) == 3'd1);
                        state      <= DISPENSE;
                    end else if (coin_ok) begin
                        credit   <= sum[1:0];
                        idle_cnt <= '0;
                    end else if (!owner_req && credit == '0) begin
                        grant <= '0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (idle_cnt == TO_LAST) begin
                        refund_out <= credit;
                        credit     <= '0;
                        grant      <= '0;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end else begin
                        idle_cnt <= idle_cnt + 8'd1;
                    end
                end
                DISPENSE: begin
                    last_b <= port_b;
                    credit <= '0;
                    grant  <= '0;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vend_arbiter.sv
// Bench for vend_arbiter: directed scenarios plus random traffic, all checked
// against a money-level session model.
module tb_vend_arbiter;

    localparam int TO = 5;

    logic       clk;
    logic       rst;
    logic [1:0] req;
    logic [1:0] sel;
    logic [1:0] din_a;
    logic [1:0] din_b;
    logic [1:0] grant;
    logic       busy;
    logic [1:0] drinks_out;
    logic       change_out;
    logic [1:0] refund_out;

    int total = 0;
    int bad   = 0;

    // Session model kept in money units (5 / 10), not credit steps.
    int owner = -1;
    int last  = 1;
    int money = 0;
    int price = 5;
    int idle  = 0;
    bit pay_pending = 0;
    int e_drinks, e_change, e_refund;

    vend_arbiter #(.TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst), .req(req), .sel(sel), .din_a(din_a), .din_b(din_b),
        .grant(grant), .busy(busy), .drinks_out(drinks_out),
        .change_out(change_out), .refund_out(refund_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic model_step(input logic r, input logic [1:0] rq, input logic [1:0] s,
                              input logic [1:0] da, input logic [1:0] db);
        int c, val;
        e_drinks = 0; e_change = 0; e_refund = 0;
        if (r) begin
            owner = -1; last = 1; money = 0; idle = 0; pay_pending = 0;
        end else if (pay_pending) begin
            last = owner; owner = -1; pay_pending = 0;
        end else if (owner < 0) begin
            if (rq != 0) begin
                owner = (rq == 3) ? 1 - last : (rq == 1 ? 0 : 1);
                price = s[owner] ? 10 : 5;
                money = 0; idle = 0;
            end
        end else begin
            c   = (owner == 0) ? da : db;
            val = (c == 1) ? 5 : (c == 2) ? 10 : 0;
            if (money + val >= price) begin
                pay_pending = 1;
                e_drinks = price / 5;
                e_change = (money + val - price == 5) ? 1 : 0;
            end else if (val > 0) begin
                money += val; idle = 0;
            end else if (!rq[owner] && money == 0) begin
                owner = -1;
            end else if (idle == TO - 1) begin
                e_refund = money / 5; owner = -1;
            end else begin
                idle++;
            end
        end
    endtask

    task automatic cycle(input logic r, input logic [1:0] rq, input logic [1:0] s,
                         input logic [1:0] da, input logic [1:0] db);
        @(negedge clk);
        rst = r; req = rq; sel = s; din_a = da; din_b = db;
        @(posedge clk);
        model_step(r, rq, s, da, db);
        #1;
        check_val("grant", grant, owner < 0 ? 0 : (1 << owner));
        check_val("busy", busy, owner < 0 ? 0 : 1);
        check_val("drinks", drinks_out, e_drinks);
        check_val("change", change_out, e_change);
        check_val("refund", refund_out, e_refund);
    endtask

    initial begin
        rst = 1'b1; req = '0; sel = '0; din_a = '0; din_b = '0;
        cycle(1, 0, 0, 0, 0);
        cycle(1, 2'b11, 2'b11, 2, 2);
        check_val("rst_grant", grant, 0);
        check_val("rst_refund", refund_out, 0);

        // Single 5-unit purchase on port A.
        cycle(0, 2'b01, 2'b00, 0, 0);
        check_val("a5_grant", grant, 1);
        cycle(0, 2'b01, 2'b00, 1, 0);
        check_val("a5_drink", drinks_out, 1);
        check_val("a5_change", change_out, 0);
        cycle(0, 2'b00, 2'b00, 0, 0);
        check_val("a5_release", grant, 0);

        // 10-unit drink paid 5 + 10, expecting change.
        cycle(0, 2'b01, 2'b01, 0, 0);
        cycle(0, 2'b01, 2'b00, 1, 0);
        cycle(0, 2'b01, 2'b00, 2, 0);
        check_val("a10_drink", drinks_out, 2);
        check_val("a10_change", change_out, 1);
        cycle(0, 2'b00, 2'b00, 0, 0);

        // Round-robin from reset.
        cycle(1, 0, 0, 0, 0);
        cycle(0, 2'b11, 2'b00, 0, 0);
        check_val("rr_first", grant, 2'b01);
        cycle(0, 2'b11, 2'b00, 1, 0);
        cycle(0, 2'b11, 2'b00, 0, 0);
        cycle(0, 2'b11, 2'b00, 0, 0);
        check_val("rr_second", grant, 2'b10);
        cycle(0, 2'b11, 2'b00, 0, 1);
        cycle(0, 2'b00, 2'b00, 0, 0);

        // Port B timeout with 5 units credited.
        cycle(0, 2'b10, 2'b10, 0, 0);
        cycle(0, 2'b10, 2'b10, 0, 1);
        for (int i = 0; i < TO - 1; i++) cycle(0, 2'b10, 2'b10, 0, 0);
        check_val("to_early", refund_out, 0);
        cycle(0, 2'b10, 2'b10, 0, 0);
        check_val("to_refund", refund_out, 1);
        check_val("to_drinks", drinks_out, 0);
        check_val("to_grant", grant, 0);

        // Foreign coin and illegal coin leave credit untouched.
        cycle(0, 2'b01, 2'b11, 0, 0);
        cycle(0, 2'b01, 2'b11, 1, 0);
        cycle(0, 2'b01, 2'b11, 3, 2);
        cycle(0, 2'b01, 2'b11, 3, 2);
        check_val("ign_drinks", drinks_out, 0);
        cycle(0, 2'b01, 2'b11, 1, 0);
        check_val("ign_pay", drinks_out, 2);
        check_val("ign_change", change_out, 0);
        cycle(0, 2'b00, 2'b00, 0, 0);

        // Reset mid-session drops credit silently.
        cycle(0, 2'b01, 2'b01, 0, 0);
        cycle(0, 2'b01, 2'b01, 1, 0);
        cycle(1, 2'b01, 2'b01, 0, 0);
        check_val("mid_rst_refund", refund_out, 0);
        check_val("mid_rst_grant", grant, 0);
        cycle(0, 2'b00, 2'b00, 0, 0);
        check_val("mid_rst_after", refund_out, 0);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            logic       r;
            logic [1:0] rq, s, da, db;
            r  = ($urandom_range(0, 63) == 0);
            rq = ($urandom_range(0, 3) == 0) ? 2'b00 : 2'($urandom);
            s  = 2'($urandom);
            da = ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'b00;
            db = ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'b00;
            cycle(r, rq, s, da, db);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
